// File: rtl/ctrl_pkg.sv
// Shared encodings for the phase-sequenced control unit: phases, opcode fields,
// write-back selects, ALU control codes and the decoded instruction class.
package ctrl_pkg;

  typedef enum logic [2:0] {
    P_IDLE = 3'd0,
    P1     = 3'd1,
    P2     = 3'd2,
    P3     = 3'd3,
    P4     = 3'd4,
    P5     = 3'd5
  } phase_e;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_IMM = 2'b10;
  localparam logic [1:0] OP_REG = 2'b11;

  localparam logic [3:0] OP3_CMP = 4'd5;
  localparam logic [3:0] OP3_MOV = 4'd6;
  localparam logic [3:0] OP3_SLL = 4'd8;
  localparam logic [3:0] OP3_SRA = 4'd11;
  localparam logic [3:0] OP3_IN  = 4'd12;
  localparam logic [3:0] OP3_OUT = 4'd13;
  localparam logic [3:0] OP3_HLT = 4'd15;

  localparam logic [2:0] OPX_LI  = 3'b000;
  localparam logic [2:0] OPX_B   = 3'b100;
  localparam logic [2:0] OPX_BCC = 3'b111;

  localparam logic [2:0] CC_BE  = 3'd0;
  localparam logic [2:0] CC_BLT = 3'd1;
  localparam logic [2:0] CC_BLE = 3'd2;
  localparam logic [2:0] CC_BNE = 3'd3;

  localparam logic [1:0] WB_DR  = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_IN  = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // Code 0 is reserved as "ALU idle"; register ops map to op3 + 1.
  localparam logic [5:0] ALU_NOP = 6'h00;
  localparam logic [5:0] ALU_ADD = 6'h01;

  typedef struct packed {
    logic alu;
    logic cmp;
    logic shift;
    logic ld;
    logic st;
    logic li;
    logic b;
    logic bcc;
    logic in_op;
    logic out_op;
    logic hlt;
    logic undef;
  } insn_class_t;

endpackage

// File: rtl/insn_decoder.sv
// Pure combinational decode of the 16-bit instruction word into class flags,
// branch condition result and ALU control code.
module insn_decoder
  import ctrl_pkg::*;
(
  input  logic [15:0]  insn,
  input  logic         s,
  input  logic         z,
  input  logic         c,
  input  logic         v,
  output insn_class_t  cls,
  output logic         cond_true,
  output logic [5:0]   alu_code
);

  logic [3:0] op3;
  logic       unused_bits;

  assign op3         = insn[7:4];
  assign unused_bits = ^{c, insn[3:0]};

  always_comb begin
    cls       = '0;
    cond_true = 1'b0;
    alu_code  = ALU_NOP;
    unique case (insn[15:14])
      OP_REG: begin
        if (op3 <= OP3_MOV) begin
          cls.alu  = 1'b1;
          cls.cmp  = (op3 == OP3_CMP);
          alu_code = {2'b00, op3} + 6'd1;
        end else if (op3 >= OP3_SLL && op3 <= OP3_SRA) begin
          cls.shift = 1'b1;
          alu_code  = {2'b00, op3} + 6'd1;
        end else if (op3 == OP3_IN) begin
          cls.in_op = 1'b1;
        end else if (op3 == OP3_OUT) begin
          cls.out_op = 1'b1;
        end else if (op3 == OP3_HLT) begin
          cls.hlt = 1'b1;
        end else begin
          cls.undef = 1'b1;
        end
      end
      OP_LD: begin
        cls.ld   = 1'b1;
        alu_code = ALU_ADD;
      end
      OP_ST: begin
        cls.st   = 1'b1;
        alu_code = ALU_ADD;
      end
      default: begin
        case (insn[13:11])
          OPX_LI: cls.li = 1'b1;
          OPX_B: begin
            cls.b    = 1'b1;
            alu_code = ALU_ADD;
          end
          OPX_BCC: begin
            alu_code = ALU_ADD;
            cls.bcc  = 1'b1;
            case (insn[10:8])
              CC_BE:   cond_true = z;
              CC_BLT:  cond_true = s ^ v;
              CC_BLE:  cond_true = z | (s ^ v);
              CC_BNE:  cond_true = ~z;
              default: begin
                cls.bcc   = 1'b0;
                cls.undef = 1'b1;
                alu_code  = ALU_NOP;
              end
            endcase
          end
          default: cls.undef = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Phase-sequenced control unit: run/stop state, phase counter and per-phase
// datapath enables. Optional single-step port enabled by SINGLE_STEP_EN.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned INSN_W     = 16,
  parameter int unsigned PHASE_W    = 3,
  parameter int unsigned UNDEF_HALT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exec,
`ifdef SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic               mem_rdy,
  input  logic [INSN_W-1:0]  instruction,
  input  logic               S,
  input  logic               Z,
  input  logic               C,
  input  logic               V,
  output logic [PHASE_W-1:0] phase,
  output logic               running,
  output logic               halted,
  output logic               ir_e,
  output logic               ar_e,
  output logic               br_e,
  output logic               dr_e,
  output logic               mdr_e,
  output logic               aluc_e,
  output logic               mem_e,
  output logic               mem_w,
  output logic               genr_w,
  output logic               pc_e,
  output logic               br_taken,
  output logic               alu_imm,
  output logic [1:0]         wb_src,
  output logic               out_e,
  output logic [5:0]         alu_instruction
);

  phase_e      phase_q, phase_d;
  logic        running_q, running_d;
  logic        halted_q, halted_d;
  logic        stop_req_q, stop_req_d;
  logic        exec_q, exec_rise;
  logic        do_halt, cond_true;
  logic [5:0]  alu_code;
  insn_class_t cls;

  insn_decoder u_dec (
    .insn      (instruction[INSN_W-1 -: 16]),
    .s         (S),
    .z         (Z),
    .c         (C),
    .v         (V),
    .cls       (cls),
    .cond_true (cond_true),
    .alu_code  (alu_code)
  );

  assign exec_rise = exec & ~exec_q;
  assign do_halt   = cls.hlt | (cls.undef & (UNDEF_HALT != 0));
  assign phase     = PHASE_W'(phase_q);
  assign running   = running_q;
  assign halted    = halted_q;

`ifdef SINGLE_STEP_EN
  logic step_q, step_rise, single_q, single_d;
  assign step_rise = step & ~step_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q    <= P_IDLE;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
      stop_req_q <= 1'b0;
      exec_q     <= 1'b0;
`ifdef SINGLE_STEP_EN
      step_q     <= 1'b0;
      single_q   <= 1'b0;
`endif
    end else begin
      phase_q    <= phase_d;
      running_q  <= running_d;
      halted_q   <= halted_d;
      stop_req_q <= stop_req_d;
      exec_q     <= exec;
`ifdef SINGLE_STEP_EN
      step_q     <= step;
      single_q   <= single_d;
`endif
    end
  end

  always_comb begin
    phase_d    = phase_q;
    running_d  = running_q;
    halted_d   = halted_q;
    stop_req_d = stop_req_q | (running_q & exec_rise);
`ifdef SINGLE_STEP_EN
    single_d   = single_q;
`endif
    case (phase_q)
      P_IDLE: begin
        stop_req_d = 1'b0;
        if (exec_rise) begin
          phase_d   = P1;
          running_d = 1'b1;
          halted_d  = 1'b0;
        end
`ifdef SINGLE_STEP_EN
        else if (step_rise && !halted_q) begin
          phase_d   = P1;
          running_d = 1'b1;
          single_d  = 1'b1;
        end
`endif
      end
      P1: if (mem_rdy) phase_d = P2;
      P2: phase_d = P3;
      P3: phase_d = (cls.ld | cls.st) ? P4 : P5;
      P4: if (mem_rdy) phase_d = P5;
      P5: begin
        // Halt discards any exec rise seen in the same cycle.
        if (do_halt) begin
          phase_d    = P_IDLE;
          running_d  = 1'b0;
          halted_d   = 1'b1;
          stop_req_d = 1'b0;
`ifdef SINGLE_STEP_EN
          single_d   = 1'b0;
`endif
        end else if (stop_req_q
`ifdef SINGLE_STEP_EN
                     || single_q
`endif
                    ) begin
          phase_d    = P_IDLE;
          running_d  = 1'b0;
          stop_req_d = 1'b0;
`ifdef SINGLE_STEP_EN
          single_d   = 1'b0;
`endif
        end else begin
          phase_d = P1;
        end
      end
      default: phase_d = P_IDLE;
    endcase
  end

  always_comb begin
    ir_e            = 1'b0;
    ar_e            = 1'b0;
    br_e            = 1'b0;
    dr_e            = 1'b0;
    mdr_e           = 1'b0;
    aluc_e          = 1'b0;
    mem_e           = 1'b0;
    mem_w           = 1'b0;
    genr_w          = 1'b0;
    pc_e            = 1'b0;
    br_taken        = 1'b0;
    alu_imm         = 1'b0;
    wb_src          = WB_DR;
    out_e           = 1'b0;
    alu_instruction = ALU_NOP;
    case (phase_q)
      P1: begin
        mem_e = 1'b1;
        ir_e  = mem_rdy;
      end
      P2: begin
        ar_e = 1'b1;
        br_e = 1'b1;
      end
      P3: begin
        dr_e            = cls.alu | cls.shift | cls.ld | cls.st | cls.b | cls.bcc;
        aluc_e          = cls.alu | cls.shift;
        alu_imm         = cls.shift | cls.ld | cls.st | cls.b | cls.bcc;
        alu_instruction = alu_code;
      end
      P4: begin
        mem_e = cls.ld | cls.st;
        mdr_e = cls.ld & mem_rdy;
        mem_w = cls.st;
      end
      P5: begin
        pc_e     = 1'b1;
        br_taken = cls.b | (cls.bcc & cond_true);
        genr_w   = (cls.alu & ~cls.cmp) | cls.shift | cls.ld | cls.in_op | cls.li;
        out_e    = cls.out_op;
        if (cls.ld)         wb_src = WB_MDR;
        else if (cls.in_op) wb_src = WB_IN;
        else if (cls.li)    wb_src = WB_IMM;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Phase-sequenced control unit for the 16-bit processor. It owns the run/stop state and the phase counter, decodes the instruction held in IR, and drives every datapath enable and mux select phase by phase. It extends the original fixed five-phase controller with three additions: a memory-ready stall handshake, skipping of the memory phase for non-memory instructions, and configurable handling of undefined opcodes.

## Interface
- INSN_W, 16, instruction width; fields are taken from the top 16 bits.
- PHASE_W, 3, width of the phase output.
- UNDEF_HALT, 1, undefined opcode: 1 = treat as HLT, 0 = treat as NOP.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- exec  in  1  run/stop request; only its rising edge is used.
- step  in  1  single-step request; only its rising edge is used. Present only with SINGLE_STEP_EN.
- mem_rdy  in  1  memory handshake; the access completes in the cycle it is high.
- instruction  in  INSN_W  IR contents.
- S, Z, C, V  in  1 each  registered flags.
- phase  out  PHASE_W  0 = idle, 1..5 = active phase.
- running  out  1  sequencer active.
- halted  out  1  HLT executed.
- ir_e, ar_e, br_e, dr_e, mdr_e, aluc_e  out  1 each  register enables; aluc_e is the flag-register write enable.
- mem_e, mem_w  out  1 each  memory enable and write.
- genr_w  out  1  general register write.
- pc_e  out  1  PC update.
- br_taken  out  1  PC source = branch target.
- alu_imm  out  1  ALU B operand = d field.
- wb_src  out  2  write-back source: 0 = DR, 1 = MDR, 2 = input port, 3 = sign_ext(d).
- out_e  out  1  output port latch.
- alu_instruction  out  6  ALU control code.

## Operation
- Instruction decode:
  - op [15:14] = 11: op3 [7:4] selects the operation.
    - 0-6: ADD, SUB, AND, OR, XOR, CMP, MOV.
    - 8-11: SLL, SLR, SRL, SRA.
    - 12: IN. 13: OUT. 15: HLT.
  - op = 00: LD. op = 01: ST.
  - op = 10: [13:11] selects the operation.
    - 000: LI.
    - 100: B.
    - 111: conditional branch; [10:8] = 0 BE (Z), 1 BLT (S^V), 2 BLE (Z|(S^V)), 3 BNE (!Z).
  - Any other code is undefined.
- Phase activity; all outputs not listed are 0:
  - P1 (fetch): mem_e=1. ir_e=mem_rdy. Phase holds while mem_rdy=0. Instruction decode is ignored in P1.
  - P2: ar_e=br_e=1.
  - P3: dr_e=1 for ALU, shift, LD, ST and branch instructions. aluc_e=1 only for op3 0-11. alu_imm=1 for shift, LD, ST and branch instructions.
  - P4, LD only: mem_e=1, mdr_e=mem_rdy.
  - P4, ST only: mem_e=1, mem_w=1.
  - P4 stall: phase holds in P4 while mem_rdy=0.
  - P4 skip: all other instructions go directly from P3 to P5.
  - P5: pc_e=1 always. br_taken=1 for B, or for a conditional branch whose condition is true.
  - P5, genr_w=1 with wb_src as follows: ALU except CMP uses 0; shifts use 0; LD uses 1; IN uses 2; LI uses 3.
  - P5, OUT: out_e=1.
- Run control:
  - In P0, when not halted, an exec rise sets running and moves to P1.
  - While running, an exec rise latches stop_req. At the end of P5 with stop_req set, the sequencer returns to P0 and running=0.
  - HLT in P5: halted=1, running=0, next phase P0.
  - While halted, an exec rise clears halted and starts execution at P1.
  - An exec rise in the same cycle as HLT in P5 is discarded; halt wins.
  - Undefined opcode: behaves as HLT when UNDEF_HALT=1, otherwise as NOP (pc_e only).

## Timing
- Reset: phase=0, running=0, halted=0, stop_req=0, all enables and selects 0, alu_instruction=0.
- Phase, running, halted and stop_req are registered. All enables are combinational from (phase, instruction, flags, mem_rdy).
- Edge detection on exec (and on step) uses one registered copy. An edge is acted on in the cycle following the rise.
- Latency with mem_rdy held high:
  - Non-memory instruction: 4 cycles (P1, P2, P3, P5).
  - LD/ST: 5 cycles.
  - Each low cycle of mem_rdy adds one cycle.
- Reset asserted mid-phase clears state immediately. The interrupted instruction is abandoned.

## Configuration
- SINGLE_STEP_EN defined:
  - The step port exists.
  - In P0, when not halted, a step rise executes exactly one instruction and returns to P0. running=1 only during that instruction.
- SINGLE_STEP_EN undefined: no step port and no step logic.

## Structure
- Package ctrl_pkg holds:
  - phase localparams P_IDLE..P5;
  - op, op3 and condition codes;
  - wb_src encodings;
  - ALU code constants.
- Sub-module insn_decoder holds the pure combinational decode: instruction class flags, branch condition and alu_instruction.

## Test plan
- Reset: assert rst low during P3 -> all outputs 0 in the same cycle; phase=0 after release.
- ADD, instruction 0xCA00, exec pulse, mem_rdy=1 -> phase sequence 1,2,3,5,1; aluc_e=1 only in P3; genr_w=1 with wb_src=0 in P5.
- LD, instruction 0x0105, mem_rdy=0 for 3 cycles in P4 -> phase holds at 4 for 4 cycles; mdr_e=1 only in the ready cycle; instruction takes 8 cycles total.
- Branches: BE 0xB805 with Z=1 -> br_taken=1 in P5; with Z=0 -> br_taken=0, pc_e=1. BLE 0xBA05 with S=1, V=0 -> br_taken=1.
- HLT 0xC0F0 -> halted=1 and phase=0 after P5. The next exec rise restarts at P1 with halted=0.
- Stop request: exec rise during P2 -> instruction completes, then phase=0 and running=0. With SINGLE_STEP_EN, a step rise runs one ADD (4 cycles) and returns to P0.
